magic_square_sequencer: RTL and testbench
=========================================

// Module: magic_square_sequencer
// PURPOSE
//  Sequential magic-square checker. Captures nine 4-bit digits of a 3x3 grid
//  and sums one line per cycle through a single shared 3-operand adder, over
//  eight lines (3 rows, 3 cols, 2 diagonals). Reports whether every line sum
//  equals the top-row sum.
//  Sits between grid-entry logic (start/ready) and the display path (done/ack).
// PARAMETERS
//  DIGIT_W  4  width of each grid digit; localparam SUM_W = DIGIT_W+2
// PORTS
//  clock          in   1      system clock, all state on posedge
//  reset          in   1      asynchronous, active-high; clears all state
//  start          in   1      request to check grid; accepted when start & ready
//  num1..num9     in   4 ea   grid digits, row-major; num1 top-left, num9 bottom-right
//  ready          out  1      high only in IDLE; new grid may be accepted
//  done           out  1      result valid; held until ack
//  ack            in   1      consumer has taken the result (honoured only in DONE)
//  sum            out  SUM_W  binary sum of the top row (reference line sum)
//  it_is_magic    out  1      1 = all eight line sums equal sum
//  mismatch_line  out  3      index of first failing line; 0 when it_is_magic
// BEHAVIOUR
//  - Reset values: state=IDLE; ready=1; done=0; sum=0; it_is_magic=0;
//    mismatch_line=0; digit regs=0; idx=0.
//  - Line order by idx: 0,1,2 = rows top..bottom; 3,4,5 = cols left..right;
//    6 = num1+num5+num9; 7 = num3+num5+num7.
//  - Adder: zero-extend each digit to SUM_W, add; no overflow (max 3*15=45 < 64).
//  - States: IDLE -> SCAN -> DONE -> IDLE.
//  - IDLE: ready=1. On edge with start=1: latch num1..num9, idx<=0, go SCAN.
//    Inputs are ignored after capture; changing them mid-scan has no effect.
//  - SCAN (ready=0, done=0): the line idx is summed combinationally from the
//    latched digits. At each edge:
//      idx==0: sum<=line, it_is_magic<=1, mismatch_line<=0.
//      idx>0 and line!=sum and it_is_magic==1: it_is_magic<=0,
//        mismatch_line<=idx.
//      idx==7: go DONE, else idx<=idx+1.
//  - Latency: start accepted at edge E0; done=1 after edge E8 (8 SCAN cycles).
//  - DONE: done=1, outputs stable. The ack edge -> IDLE and done<=0. sum,
//    it_is_magic and mismatch_line keep their values until the next scan
//    reaches idx 0.
//  - start while not IDLE: ignored (no queueing). If start and ack are high in
//    the same DONE cycle, ack is taken and start is dropped; a new start is
//    needed in IDLE.
//  - ack outside DONE: ignored.
//  - reset asserted mid-SCAN or mid-DONE: immediate return to reset values; the
//    partial result is discarded and no done pulse is produced.
// CONFIGURATION
//  EARLY_ABORT_EN defined:
//    - On the edge that records the first mismatch at idx k, go DONE directly.
//    - done=1 after edge E(k+1).
//    - Magic grids still take the full 8 cycles.
//  EARLY_ABORT_EN undefined:
//    - Always scan all 8 lines; done after E8 regardless of mismatch.
//    - mismatch_line still reports the first failure.
// TESTING
//  1. Grid 2,7,6/9,5,1/4,3,8 -> done after E8, sum=15, it_is_magic=1,
//     mismatch_line=0.
//  2. Grid 1,2,3/2,3,1/3,1,2 -> sum=6, it_is_magic=0, mismatch_line=7
//     (anti-diagonal=9); done after E8 in both configs.
//  3. Grid 1,1,1/1,1,2/1,1,1 -> it_is_magic=0, mismatch_line=1.
//     EARLY_ABORT_EN: done after E2. Otherwise: done after E8.
//  4. All digits 15 -> sum=45, it_is_magic=1 (no width overflow).
//  5. Drive start pulses during SCAN and DONE, and ack during SCAN -> both
//     ignored; exactly one done per accepted start, held until ack, then ready=1.
//  6. Assert reset at the 4th SCAN cycle -> next cycle ready=1, done=0,
//     outputs 0; a fresh start of grid 1 -> correct result after E8.

Source files
------------

// File: rtl/magic_square_sequencer.sv
// Sequential 3x3 magic-square checker: one line summed per cycle.
// Ports: clock/reset, start/ready in, num1..num9 digits, done/ack out,
//   sum (top-row sum), it_is_magic, mismatch_line.
// Option: define EARLY_ABORT_EN to finish on the first failing line.
module magic_square_sequencer #(
  parameter int DIGIT_W = 4,
  localparam int SUM_W = DIGIT_W + 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [DIGIT_W-1:0] num1,
  input  logic [DIGIT_W-1:0] num2,
  input  logic [DIGIT_W-1:0] num3,
  input  logic [DIGIT_W-1:0] num4,
  input  logic [DIGIT_W-1:0] num5,
  input  logic [DIGIT_W-1:0] num6,
  input  logic [DIGIT_W-1:0] num7,
  input  logic [DIGIT_W-1:0] num8,
  input  logic [DIGIT_W-1:0] num9,
  output logic               ready,
  output logic               done,
  input  logic               ack,
  output logic [SUM_W-1:0]   sum,
  output logic               it_is_magic,
  output logic [2:0]         mismatch_line
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  logic [DIGIT_W-1:0] g [9];
  logic [2:0] idx;

  logic [DIGIT_W-1:0] op_a;
  logic [DIGIT_W-1:0] op_b;
  logic [DIGIT_W-1:0] op_c;
  logic [SUM_W-1:0]   line;
  logic               miss;
  logic               last;

  // Operand select for the shared adder; g[] is row-major.
  always_comb begin
    op_a = g[0];
    op_b = g[1];
    op_c = g[2];
    case (idx)
      3'd0: begin op_a = g[0]; op_b = g[1]; op_c = g[2]; end
      3'd1: begin op_a = g[3]; op_b = g[4]; op_c = g[5]; end
      3'd2: begin op_a = g[6]; op_b = g[7]; op_c = g[8]; end
      3'd3: begin op_a = g[0]; op_b = g[3]; op_c = g[6]; end
      3'd4: begin op_a = g[1]; op_b = g[4]; op_c = g[7]; end
      3'd5: begin op_a = g[2]; op_b = g[5]; op_c = g[8]; end
      3'd6: begin op_a = g[0]; op_b = g[4]; op_c = g[8]; end
      3'd7: begin op_a = g[2]; op_b = g[4]; op_c = g[6]; end
      default: begin op_a = g[0]; op_b = g[1]; op_c = g[2]; end
    endcase
  end

  assign line = {2'b00, op_a} + {2'b00, op_b} + {2'b00, op_c};

  // Only the first failing line is recorded.
  assign miss = (idx != 3'd0) && (line != sum) && it_is_magic;

`ifdef EARLY_ABORT_EN
  assign last = (idx == 3'd7) || miss;
`else
  assign last = (idx == 3'd7);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      ready         <= 1'b1;
      done          <= 1'b0;
      sum           <= '0;
      it_is_magic   <= 1'b0;
      mismatch_line <= 3'd0;
      idx           <= 3'd0;
      for (int i = 0; i < 9; i++) g[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            g[0]  <= num1;
            g[1]  <= num2;
            g[2]  <= num3;
            g[3]  <= num4;
            g[4]  <= num5;
            g[5]  <= num6;
            g[6]  <= num7;
            g[7]  <= num8;
            g[8]  <= num9;
            idx   <= 3'd0;
            ready <= 1'b0;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (idx == 3'd0) begin
            sum           <= line;
            it_is_magic   <= 1'b1;
            mismatch_line <= 3'd0;
          end else if (miss) begin
            it_is_magic   <= 1'b0;
            mismatch_line <= idx;
          end
          if (last) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        DONE: begin
          if (ack) begin
            done  <= 1'b0;
            ready <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_magic_square_sequencer.sv
// Directed bench for magic_square_sequencer.
// Table of grids plus hand-written handshake and reset sequences.
module tb_magic_square_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] n1, n2, n3, n4, n5, n6, n7, n8, n9;
  logic       ready;
  logic       done;
  logic       ack;
  logic [5:0] sum;
  logic       it_is_magic;
  logic [2:0] mismatch_line;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  magic_square_sequencer #(.DIGIT_W(4)) dut (
    .clock(clock), .reset(reset), .start(start),
    .num1(n1), .num2(n2), .num3(n3),
    .num4(n4), .num5(n5), .num6(n6),
    .num7(n7), .num8(n8), .num9(n9),
    .ready(ready), .done(done), .ack(ack),
    .sum(sum), .it_is_magic(it_is_magic),
    .mismatch_line(mismatch_line)
  );

  typedef logic [8:0][3:0] grid_t;

  typedef struct {
    grid_t g;
    int    e_sum;
    int    e_magic;
    int    e_line;
    int    lat_full;
    int    lat_abort;
  } vec_t;

  vec_t tv [6];

  function automatic grid_t mk(input int a, b, c, d, e, f, h, i, j);
    grid_t r;
    r[0] = 4'(a); r[1] = 4'(b); r[2] = 4'(c);
    r[3] = 4'(d); r[4] = 4'(e); r[5] = 4'(f);
    r[6] = 4'(h); r[7] = 4'(i); r[8] = 4'(j);
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input grid_t g);
    n1 = g[0]; n2 = g[1]; n3 = g[2];
    n4 = g[3]; n5 = g[4]; n6 = g[5];
    n7 = g[6]; n8 = g[7]; n9 = g[8];
  endtask

  // Call at a negedge; returns edges after E0 until done (or -1).
  task automatic launch_and_wait(input grid_t g, output int lat);
    drive(g);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic do_ack();
    @(negedge clock);
    ack = 1'b1;
    @(posedge clock);
    #1;
    ack = 1'b0;
  endtask

  int lat;
  int exp_lat;
  int pulses;

  initial begin
    tv[0] = '{mk(2,7,6, 9,5,1, 4,3,8), 15, 1, 0, 8, 8};
    tv[1] = '{mk(1,2,3, 2,3,1, 3,1,2),  6, 0, 7, 8, 8};
    tv[2] = '{mk(1,1,1, 1,1,2, 1,1,1),  3, 0, 1, 8, 2};
    tv[3] = '{mk(15,15,15, 15,15,15, 15,15,15), 45, 1, 0, 8, 8};
    tv[4] = '{mk(1,2,3, 3,2,1, 0,0,0),  6, 0, 2, 8, 3};
    tv[5] = '{mk(1,2,3, 3,1,2, 2,3,1),  6, 0, 6, 8, 7};

    reset = 1'b1;
    start = 1'b0;
    ack   = 1'b0;
    drive('0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_magic", it_is_magic, 0);
    chk("rst_line", mismatch_line, 0);
    reset = 1'b0;

    for (int v = 0; v < 6; v++) begin
      @(negedge clock);
`ifdef EARLY_ABORT_EN
      exp_lat = tv[v].lat_abort;
`else
      exp_lat = tv[v].lat_full;
`endif
      launch_and_wait(tv[v].g, lat);
      chk($sformatf("v%0d_latency", v), lat, exp_lat);
      chk($sformatf("v%0d_sum", v), sum, tv[v].e_sum);
      chk($sformatf("v%0d_magic", v), it_is_magic, tv[v].e_magic);
      chk($sformatf("v%0d_line", v), mismatch_line, tv[v].e_line);
      do_ack();
      chk($sformatf("v%0d_ready_after_ack", v), ready, 1);
      chk($sformatf("v%0d_done_after_ack", v), done, 0);
    end

    // Ignored start/ack during SCAN, input changes mid-scan.
    @(negedge clock);
    drive(tv[0].g);
    start = 1'b1;
    @(posedge clock);
    #1;
    drive('0);
    pulses = 0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      start = k[0];
      ack   = ~k[0];
      @(posedge clock);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    ack   = 1'b0;
    chk("busy_latency", lat, 8);
    chk("busy_ready_low", ready, 0);
    chk("busy_sum", sum, 15);
    chk("busy_magic", it_is_magic, 1);

    // Held in DONE despite start pulses.
    for (int k = 0; k < 4; k++) begin
      start = k[0];
      @(posedge clock);
      #1;
      if (done) pulses++;
    end
    start = 1'b0;
    chk("done_held", pulses, 4);
    chk("done_ready_low", ready, 0);

    // ack and start together: ack wins, start dropped.
    @(negedge clock);
    ack   = 1'b1;
    start = 1'b1;
    @(posedge clock);
    #1;
    ack   = 1'b0;
    start = 1'b0;
    chk("ackstart_ready", ready, 1);
    chk("ackstart_done", done, 0);
    repeat (3) @(posedge clock);
    #1;
    chk("start_dropped_ready", ready, 1);
    chk("kept_sum", sum, 15);
    chk("kept_magic", it_is_magic, 1);

    // Reset during the 4th SCAN cycle.
    @(negedge clock);
    drive(tv[0].g);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("midrst_ready", ready, 1);
    chk("midrst_done", done, 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_magic", it_is_magic, 0);
    chk("midrst_line", mismatch_line, 0);
    @(negedge clock);
    reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock);
      #1;
      if (done) pulses++;
    end
    chk("midrst_no_done", pulses, 0);

    @(negedge clock);
    launch_and_wait(tv[0].g, lat);
    chk("post_rst_latency", lat, 8);
    chk("post_rst_sum", sum, 15);
    chk("post_rst_magic", it_is_magic, 1);
    chk("post_rst_line", mismatch_line, 0);
    do_ack();
    chk("post_rst_ready", ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
